// File: rtl/qlearn_agent_ctrl.sv
// qlearn_agent_ctrl: episode sequencer between an RL environment and a Q-learning update accelerator
module qlearn_agent_ctrl #(
  parameter int N_ACT     = 4,
  parameter int Q_W       = 16,
  parameter int S_W       = 6,
  parameter int ACC_LAT   = 3,
  parameter int MAX_STEPS = 63
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [S_W-1:0]         start_state,
  input  logic [S_W-1:0]         goal_state,
  input  logic [7:0]             epsilon,
  output logic                   act_valid,
  input  logic                   act_ready,
  output logic [1:0]             act,
  input  logic                   obs_valid,
  input  logic [S_W-1:0]         obs_state,
  input  logic signed [15:0]     obs_reward,
  output logic                   acc_en,
  output logic [S_W-1:0]         acc_cur_state,
  output logic [S_W-1:0]         acc_next_state,
  output logic [3:0]             acc_action,
  output logic signed [15:0]     acc_reward,
  input  logic [N_ACT*Q_W-1:0]   acc_q_row,
  output logic                   busy,
  output logic                   done,
  output logic [5:0]             steps
);
  localparam int CW = ACC_LAT > 1 ? $clog2(ACC_LAT) : 1;
  typedef enum logic [2:0] {IDLE, SELECT, ACT, OBSERVE, UPDATE, WAIT, DONE} state_t;
  state_t               r_state;
  logic [15:0]          r_lfsr;
  logic [S_W-1:0]       r_cur;
  logic [S_W-1:0]       r_goal;
  logic [7:0]           r_eps;
  logic                 r_first;
  logic [CW-1:0]        r_wcnt;
  logic                 w_fb;
  logic                 w_explore;
  logic                 w_end;
  logic [1:0]           w_best_idx;
  logic signed [Q_W-1:0] w_best;
  assign w_fb      = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_explore = r_first || (r_lfsr[7:0] < r_eps);
  assign w_end     = (r_cur == r_goal) || (steps == 6'(MAX_STEPS));
  // strict greater-than keeps the lowest index on ties
  always_comb begin
    w_best     = acc_q_row[Q_W-1:0];
    w_best_idx = '0;
    for (int i = 1; i < N_ACT; i++)
      if ($signed(acc_q_row[i*Q_W +: Q_W]) > w_best) begin
        w_best     = acc_q_row[i*Q_W +: Q_W];
        w_best_idx = 2'(i);
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_lfsr         <= 16'hACE1;
      r_first        <= 1'b1;
      r_wcnt         <= '0;
      act_valid      <= 1'b0;
      act            <= '0;
      acc_en         <= 1'b0;
      acc_cur_state  <= '0;
      acc_next_state <= '0;
      acc_action     <= '0;
      acc_reward     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      steps          <= '0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
      case (r_state)
        IDLE: if (start) begin
          r_cur   <= start_state;
          r_goal  <= goal_state;
          r_eps   <= epsilon;
          steps   <= '0;
          r_first <= 1'b1;
          busy    <= 1'b1;
          r_state <= SELECT;
        end
        SELECT: begin
          act       <= w_explore ? r_lfsr[9:8] : w_best_idx;
          act_valid <= 1'b1;
          r_state   <= ACT;
        end
        ACT: if (act_ready) begin
          act_valid <= 1'b0;
          r_state   <= OBSERVE;
        end
        OBSERVE: if (obs_valid) begin
          acc_en         <= 1'b1;
          acc_cur_state  <= r_cur;
          acc_next_state <= obs_state;
          acc_action     <= {2'b00, act};
          acc_reward     <= obs_reward;
          r_state        <= UPDATE;
        end
        UPDATE: begin
          acc_en  <= 1'b0;
          steps   <= steps + 6'd1;
          r_cur   <= acc_next_state;
          r_first <= 1'b0;
          r_wcnt  <= '0;
          r_state <= WAIT;
        end
        WAIT: if (r_wcnt == CW'(ACC_LAT - 1)) begin
          done    <= w_end;
          r_state <= w_end ? DONE : SELECT;
        end else r_wcnt <= r_wcnt + 1'b1;
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
